edge_event_arbiter: RTL and testbench

Multi-channel rising-edge event scheduler. Each of N level inputs gets its own rising edge detector. Detected edges are queued per channel as saturating pending counts. A round-robin arbiter then serialises them into one valid/ready event stream that a single downstream consumer drains, such as a shared display or counter update path. It sits between synchronised button/switch inputs and the shared datapath those inputs control.

---
 rtl/edge_event_arbiter_if.sv | 24 ++
 rtl/edge_event_arbiter.sv | 147 ++++++++++++++
 tb/tb_edge_event_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_arbiter_if.sv
// Event-stream bundle between the edge_event_arbiter and its environment.
// The slave modport is the arbiter's view and the master modport is the driving side.
interface edge_event_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    signl;
  logic            evt_ready;
  logic            clr_ovf;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic [N-1:0]    pending;
  logic [N-1:0]    ovf;

  modport master (
    output signl, evt_ready, clr_ovf,
    input  evt_valid, evt_id, pending, ovf
  );

  modport slave (
    input  signl, evt_ready, clr_ovf,
    output evt_valid, evt_id, pending, ovf
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel rising-edge detectors feeding saturating pending counters,
// serialised onto one valid/ready event stream by a round-robin arbiter.
module edge_event_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  edge_event_arbiter_if.slave bus
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = '1;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     prev;
  logic [N-1:0]     edge_v;
  logic [N-1:0]     deq;
  logic [N-1:0]     nonzero;
  logic [N-1:0]     ovf_set;
  logic [N-1:0]     ovf_r;
  logic [CNT_W-1:0] pend [N];
  logic             hs;
  logic             evt_valid_r;
  logic             valid_nxt;
  logic [ID_W-1:0]  evt_id_r;
  logic [ID_W-1:0]  id_nxt;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  last_nxt;
  logic [ID_W-1:0]  pick;
  logic             found;
  logic [ID_W:0]    cand;

  // prev keeps tracking the inputs through reset so a level held across
  // reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    prev <= bus.signl;
  end

  assign edge_v = bus.signl & ~prev;
  assign hs     = evt_valid_r & bus.evt_ready;

  always_comb begin
    deq     = '0;
    nonzero = '0;
    ovf_set = '0;
    for (int i = 0; i < N; i++) begin
      deq[i]     = hs && (evt_id_r == ID_W'(i));
      nonzero[i] = (pend[i] != '0);
      ovf_set[i] = edge_v[i] && (pend[i] == MAX_CNT) && !deq[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (edge_v[i] && !deq[i]) begin
          if (pend[i] != MAX_CNT) begin
            pend[i] <= pend[i] + 1'b1;
          end
        end else if (deq[i] && !edge_v[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

  // A fresh overflow in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= '0;
    end else begin
      ovf_r <= (bus.clr_ovf ? '0 : ovf_r) | ovf_set;
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N)) begin
        cand = cand - (ID_W+1)'(N);
      end
      if (!found && nonzero[cand[ID_W-1:0]]) begin
        pick  = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = evt_valid_r;
    id_nxt    = evt_id_r;
    last_nxt  = last;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (found) begin
          id_nxt    = pick;
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        valid_nxt = 1'b1;
        if (hs) begin
          last_nxt  = evt_id_r;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      evt_valid_r <= 1'b0;
      evt_id_r    <= '0;
      last        <= LAST_RST;
    end else begin
      state       <= state_nxt;
      evt_valid_r <= valid_nxt;
      evt_id_r    <= id_nxt;
      last        <= last_nxt;
    end
  end

  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_id    = evt_id_r;
  assign bus.pending   = nonzero;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed test-plan steps followed by random traffic, all checked cycle by
// cycle against a behavioural model of the pending counts and offer stream.
module tb_edge_event_arbiter;
  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  edge_event_arbiter_if #(.N(N)) bus ();

  edge_event_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           checks   = 0;
  int           failures = 0;
  int           m_pend [N];
  logic [N-1:0] m_prev   = '0;
  logic [N-1:0] m_ovf    = '0;
  bit           m_valid  = 1'b0;
  int           m_id     = 0;
  int           m_last   = N - 1;
  int           cyc      = 0;
  int           hs_count = 0;
  int           hs_ids[$];
  int           hs_cycles[$];
  int           vcount;

  task automatic applyStimulus(input logic [N-1:0] sig, input logic ready,
                               input logic clr, input logic r);
    bus.signl     = sig;
    bus.evt_ready = ready;
    bus.clr_ovf   = clr;
    rst           = r;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] exp_pending;
    exp_pending = '0;
    for (int i = 0; i < N; i++) exp_pending[i] = (m_pend[i] != 0);
    checkValue("evt_valid", 32'(bus.evt_valid), 32'(m_valid));
    checkValue("evt_id", 32'(bus.evt_id), 32'(m_id));
    checkValue("pending", 32'(bus.pending), 32'(exp_pending));
    checkValue("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask

  // Advance the model by one clock using the rules of the block, then clock
  // the DUT and compare every output just after the edge.
  task automatic tick();
    logic [N-1:0] edges;
    bit           hs;
    int           old_id;
    bit           dq;
    edges  = bus.signl & ~m_prev;
    hs     = m_valid && bus.evt_ready;
    old_id = m_id;
    if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
      hs_count++;
      hs_ids.push_back(int'(bus.evt_id));
      hs_cycles.push_back(cyc);
    end
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ovf   = '0;
      m_valid = 1'b0;
      m_id    = 0;
      m_last  = N - 1;
    end else begin
      if (m_valid) begin
        if (hs) begin
          m_last  = m_id;
          m_valid = 1'b0;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (m_pend[c] != 0) begin
            m_id    = c;
            m_valid = 1'b1;
            break;
          end
        end
      end
      if (bus.clr_ovf) m_ovf = '0;
      for (int i = 0; i < N; i++) begin
        dq = hs && (old_id == i);
        if (edges[i] && !dq) begin
          if (m_pend[i] == MAX) m_ovf[i] = 1'b1;
          else m_pend[i] = m_pend[i] + 1;
        end else if (dq && !edges[i]) begin
          m_pend[i] = m_pend[i] - 1;
        end
      end
    end
    m_prev = bus.signl;
    @(posedge clk);
    cyc++;
    #1;
    checkOutput();
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    applyStimulus('0, 1'b0, 1'b0, 1'b1);

    // Inputs already high at reset release must not raise events.
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    vcount = 0;
    repeat (10) begin
      tick();
      if (bus.evt_valid === 1'b1) vcount++;
    end
    checkValue("t1_valid_cycles", 32'(vcount), 0);
    checkValue("t1_pending", 32'(bus.pending), 0);

    // Single edge on channel 2 with the consumer ready.
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    checkValue("t2_pending_k", 32'(bus.pending), 32'h4);
    checkValue("t2_valid_k", 32'(bus.evt_valid), 0);
    tick();
    checkValue("t2_valid_k1", 32'(bus.evt_valid), 1);
    checkValue("t2_id_k1", 32'(bus.evt_id), 2);
    tick();
    checkValue("t2_valid_k2", 32'(bus.evt_valid), 0);
    checkValue("t2_pending_k2", 32'(bus.pending), 0);
    vcount = 0;
    repeat (4) begin
      tick();
      if (bus.evt_valid === 1'b1) vcount++;
    end
    checkValue("t2_no_repeat", 32'(vcount), 0);

    // Simultaneous edges on every channel after reset.
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    hs_count = 0;
    hs_ids.delete();
    hs_cycles.delete();
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (12) tick();
    checkValue("t3_hs_count", 32'(hs_count), 4);
    for (int i = 0; i < 4; i++) begin
      checkValue("t3_id_order", (i < hs_ids.size()) ? 32'(hs_ids[i]) : 32'hFFFF_FFFF, 32'(i));
    end
    for (int i = 1; i < 4; i++) begin
      checkValue("t3_spacing",
                 (i < hs_cycles.size()) ? 32'(hs_cycles[i] - hs_cycles[i-1]) : 32'hFFFF_FFFF, 2);
    end
    checkValue("t3_valid_end", 32'(bus.evt_valid), 0);
    checkValue("t3_pending_end", 32'(bus.pending), 0);

    // Back-pressure while three edges arrive on channel 1.
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    for (int e = 0; e < 3; e++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      checkValue("t4_valid_held", 32'(bus.evt_valid), 1);
      checkValue("t4_id_held", 32'(bus.evt_id), 1);
    end
    checkValue("t4_ovf_none", 32'(bus.ovf), 0);
    hs_count = 0;
    hs_ids.delete();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    checkValue("t4_hs_count", 32'(hs_count), 3);
    foreach (hs_ids[i]) checkValue("t4_hs_id", 32'(hs_ids[i]), 1);

    // Saturation and overflow on channel 0.
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
      tick();
      if (e == 3) checkValue("t5_ovf_before", 32'(bus.ovf[0]), 0);
      if (e == 4) checkValue("t5_ovf_after", 32'(bus.ovf[0]), 1);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    hs_count = 0;
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    checkValue("t5_hs_count", 32'(hs_count), 3);
    checkValue("t5_ovf_sticky", 32'(bus.ovf), 1);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkValue("t5_ovf_cleared", 32'(bus.ovf), 0);
    tick();

    // Fairness after serving channel 2, then reset during an offer.
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkValue("t6_fair_valid", 32'(bus.evt_valid), 1);
    checkValue("t6_fair_id3", 32'(bus.evt_id), 3);
    applyStimulus(4'b1001, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkValue("t6_fair_id0", 32'(bus.evt_id), 0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkValue("t6_offer_before_rst", 32'(bus.evt_valid), 1);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b1);
    tick();
    checkValue("t6_rst_valid", 32'(bus.evt_valid), 0);
    checkValue("t6_rst_pending", 32'(bus.pending), 0);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkValue("t6_restart_id", 32'(bus.evt_id), 0);

    // Random traffic against the model.
    repeat (800) begin
      applyStimulus(N'($urandom_range(0, (1 << N) - 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 63) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
